// File: rtl/decode_stage.sv
// RV32I decode stage: register-file address slicing, write-back bypass,
// immediate and control decode, and the ID/EX pipeline register.
module decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic [4:0]      rf_rs1,
   output logic [4:0]      rf_rs2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic            wb_wen,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_wdata,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_alt,
   output logic            ex_is_lui,
   output logic            ex_is_auipc,
   output logic            ex_is_jal,
   output logic            ex_is_jalr,
   output logic            ex_is_branch,
   output logic            ex_is_load,
   output logic            ex_is_store,
   output logic            ex_is_op,
   output logic            ex_is_opimm,
   output logic            ex_reg_wen,
   output logic            ex_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

   logic [6:0]      opc;
   logic [4:0]      d_rd;
   logic            d_lui, d_auipc, d_jal, d_jalr, d_branch;
   logic            d_load, d_store, d_op, d_opimm, d_illegal;
   logic            d_reg_wen;
   logic [XLEN-1:0] d_imm;
   logic [XLEN-1:0] d_rs1_val, d_rs2_val;
   logic            use_rs1, use_rs2;
   logic            hazard, advance, accept;

   assign opc    = if_instr[6:0];
   assign d_rd   = if_instr[11:7];
   assign rf_rs1 = if_instr[19:15];
   assign rf_rs2 = if_instr[24:20];

   assign d_lui     = (opc == OPC_LUI);
   assign d_auipc   = (opc == OPC_AUIPC);
   assign d_jal     = (opc == OPC_JAL);
   assign d_jalr    = (opc == OPC_JALR);
   assign d_branch  = (opc == OPC_BRANCH);
   assign d_load    = (opc == OPC_LOAD);
   assign d_store   = (opc == OPC_STORE);
   assign d_op      = (opc == OPC_OP);
   assign d_opimm   = (opc == OPC_OPIMM);
   assign d_illegal = ~(d_lui | d_auipc | d_jal | d_jalr | d_branch |
                        d_load | d_store | d_op | d_opimm);
   assign d_reg_wen = (d_lui | d_auipc | d_jal | d_jalr | d_load | d_op | d_opimm) &&
                      (d_rd != 5'd0);

   always_comb begin
      d_imm = '0;
      if (d_load || d_jalr || d_opimm)
         d_imm = {{20{if_instr[31]}}, if_instr[31:20]};
      else if (d_store)
         d_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      else if (d_branch)
         d_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
      else if (d_lui || d_auipc)
         d_imm = {if_instr[31:12], 12'b0};
      else if (d_jal)
         d_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};
   end

   // x0 is never bypassed: its register-file data is already the architectural zero.
   assign d_rs1_val = (wb_wen && (wb_rd != 5'd0) && (wb_rd == rf_rs1)) ? wb_wdata : rf_rdata1;
   assign d_rs2_val = (wb_wen && (wb_rd != 5'd0) && (wb_rd == rf_rs2)) ? wb_wdata : rf_rdata2;

   assign use_rs1 = d_jalr | d_branch | d_load | d_store | d_op | d_opimm;
   assign use_rs2 = d_branch | d_store | d_op;
   assign hazard  = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((use_rs1 && (ex_rd == rf_rs1)) || (use_rs2 && (ex_rd == rf_rs2)));

   // Handshake: a transfer happens on an edge where valid && ready are both high;
   // ready may depend on valid-independent state only, and a producer holds its
   // payload stable while valid && !ready. Flush forces if_ready so fetch drains.
   assign advance  = !ex_valid || ex_ready;
   assign if_ready = flush || (advance && !hazard);
   assign accept   = if_valid && if_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1_val   <= '0;
         ex_rs2_val   <= '0;
         ex_imm       <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_funct3    <= '0;
         ex_alt       <= 1'b0;
         ex_is_lui    <= 1'b0;
         ex_is_auipc  <= 1'b0;
         ex_is_jal    <= 1'b0;
         ex_is_jalr   <= 1'b0;
         ex_is_branch <= 1'b0;
         ex_is_load   <= 1'b0;
         ex_is_store  <= 1'b0;
         ex_is_op     <= 1'b0;
         ex_is_opimm  <= 1'b0;
         ex_reg_wen   <= 1'b0;
         ex_illegal   <= 1'b0;
      end else if (flush) begin
         ex_valid   <= 1'b0;
         ex_reg_wen <= 1'b0;
      end else if (accept) begin
         ex_valid     <= 1'b1;
         ex_pc        <= if_pc;
         ex_rs1_val   <= d_rs1_val;
         ex_rs2_val   <= d_rs2_val;
         ex_imm       <= d_imm;
         ex_rs1       <= rf_rs1;
         ex_rs2       <= rf_rs2;
         ex_rd        <= d_rd;
         ex_funct3    <= if_instr[14:12];
         ex_alt       <= if_instr[30];
         ex_is_lui    <= d_lui;
         ex_is_auipc  <= d_auipc;
         ex_is_jal    <= d_jal;
         ex_is_jalr   <= d_jalr;
         ex_is_branch <= d_branch;
         ex_is_load   <= d_load;
         ex_is_store  <= d_store;
         ex_is_op     <= d_op;
         ex_is_opimm  <= d_opimm;
         ex_reg_wen   <= d_reg_wen;
         ex_illegal   <= d_illegal;
      end else if (advance) begin
         // Bubble: payload fields go stale but can no longer cause a write.
         ex_valid   <= 1'b0;
         ex_reg_wen <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table plus hand-written
// sequences for reset, load-use stall, backpressure, flush and async reset.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;
   logic [4:0]  rf_rs1, rf_rs2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        wb_wen;
   logic [4:0]  wb_rd;
   logic [31:0] wb_wdata;
   logic        flush;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_alt;
   logic        ex_is_lui, ex_is_auipc, ex_is_jal, ex_is_jalr, ex_is_branch;
   logic        ex_is_load, ex_is_store, ex_is_op, ex_is_opimm;
   logic        ex_reg_wen, ex_illegal;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
      .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_alt(ex_alt),
      .ex_is_lui(ex_is_lui), .ex_is_auipc(ex_is_auipc), .ex_is_jal(ex_is_jal),
      .ex_is_jalr(ex_is_jalr), .ex_is_branch(ex_is_branch), .ex_is_load(ex_is_load),
      .ex_is_store(ex_is_store), .ex_is_op(ex_is_op), .ex_is_opimm(ex_is_opimm),
      .ex_reg_wen(ex_reg_wen), .ex_illegal(ex_illegal)
   );

   // class order: {lui, auipc, jal, jalr, branch, load, store, op, opimm}
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
      logic        wb_wen;
      logic [4:0]  wb_rd;
      logic [31:0] wb_wdata;
      logic [31:0] e_imm;
      logic [31:0] e_rs1_val;
      logic [31:0] e_rs2_val;
      logic [4:0]  e_rs1;
      logic [4:0]  e_rs2;
      logic [4:0]  e_rd;
      logic [2:0]  e_f3;
      logic        e_alt;
      logic [8:0]  e_cls;
      logic        e_wen;
      logic        e_ill;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [8:0] cls_now();
      return {ex_is_lui, ex_is_auipc, ex_is_jal, ex_is_jalr, ex_is_branch,
              ex_is_load, ex_is_store, ex_is_op, ex_is_opimm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_valid  = 1'b0;
      if_instr  = 32'h0;
      if_pc     = 32'h0;
      rf_rdata1 = 32'h0;
      rf_rdata2 = 32'h0;
      wb_wen    = 1'b0;
      wb_rd     = 5'd0;
      wb_wdata  = 32'h0;
      flush     = 1'b0;
   endtask

   task automatic present(input logic [31:0] instr, input logic [31:0] pc);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
   endtask

   initial begin
      //          instr         pc        rd1       rd2      wen  wrd  wdata         imm           rs1v          rs2v     rs1 rs2 rd  f3 alt cls            wen ill
      vecs[0]  = '{32'h00500093, 32'h100, 32'h0,  32'h0,  1'b0, 5'd0,  32'h0,        32'h5,        32'h0,        32'h0,        5'd0,  5'd5,  5'd1,  3'd0, 1'b0, 9'b000000001, 1'b1, 1'b0};
      vecs[1]  = '{32'h004101B3, 32'h104, 32'h11, 32'h22, 1'b1, 5'd2,  32'hABCD,     32'h0,        32'hABCD,     32'h22,       5'd2,  5'd4,  5'd3,  3'd0, 1'b0, 9'b000000010, 1'b1, 1'b0};
      vecs[2]  = '{32'h004101B3, 32'h108, 32'h11, 32'h22, 1'b1, 5'd0,  32'hABCD,     32'h0,        32'h11,       32'h22,       5'd2,  5'd4,  5'd3,  3'd0, 1'b0, 9'b000000010, 1'b1, 1'b0};
      vecs[3]  = '{32'hFE532E23, 32'h10C, 32'h66, 32'h77, 1'b1, 5'd5,  32'h55,       32'hFFFFFFFC, 32'h66,       32'h55,       5'd6,  5'd5,  5'd28, 3'd2, 1'b1, 9'b000000100, 1'b0, 1'b0};
      vecs[4]  = '{32'hFE208CE3, 32'h110, 32'h1,  32'h2,  1'b0, 5'd0,  32'h0,        32'hFFFFFFF8, 32'h1,        32'h2,        5'd1,  5'd2,  5'd25, 3'd0, 1'b1, 9'b000010000, 1'b0, 1'b0};
      vecs[5]  = '{32'h123453B7, 32'h114, 32'h3,  32'h4,  1'b0, 5'd0,  32'h0,        32'h12345000, 32'h3,        32'h4,        5'd8,  5'd3,  5'd7,  3'd5, 1'b0, 9'b100000000, 1'b1, 1'b0};
      vecs[6]  = '{32'h001000EF, 32'h118, 32'h5,  32'h6,  1'b0, 5'd0,  32'h0,        32'h00000800, 32'h5,        32'h6,        5'd0,  5'd1,  5'd1,  3'd0, 1'b0, 9'b001000000, 1'b1, 1'b0};
      vecs[7]  = '{32'h0000007F, 32'h11C, 32'h7,  32'h8,  1'b0, 5'd0,  32'h0,        32'h0,        32'h7,        32'h8,        5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 9'b000000000, 1'b0, 1'b1};
      vecs[8]  = '{32'h00008067, 32'h120, 32'h9,  32'hA,  1'b0, 5'd0,  32'h0,        32'h0,        32'h9,        32'hA,        5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 9'b000100000, 1'b0, 1'b0};
      vecs[9]  = '{32'hFFFFF297, 32'h124, 32'hB,  32'hC,  1'b1, 5'd31, 32'hDEADBEEF, 32'hFFFFF000, 32'hDEADBEEF, 32'hDEADBEEF, 5'd31, 5'd31, 5'd5,  3'd7, 1'b1, 9'b010000000, 1'b1, 1'b0};
      vecs[10] = '{32'hFFF12283, 32'h128, 32'hD,  32'hE,  1'b0, 5'd0,  32'h0,        32'hFFFFFFFF, 32'hD,        32'hE,        5'd2,  5'd31, 5'd5,  3'd2, 1'b1, 9'b000001000, 1'b1, 1'b0};

      // clock/reset
      idle_inputs();
      ex_ready = 1'b1;
      rst = 1'b1;
      step();
      step();
      chk("reset_ex_valid", {31'b0, ex_valid}, 32'h0);
      chk("reset_reg_wen", {31'b0, ex_reg_wen}, 32'h0);
      chk("reset_ex_pc", ex_pc, 32'h0);
      chk("reset_ex_imm", ex_imm, 32'h0);
      chk("reset_cls", {23'b0, cls_now()}, 32'h0);
      chk("reset_if_ready", {31'b0, if_ready}, 32'h1);
      rst = 1'b0;
      step();

      // decode table: accept each vector, then one idle bubble
      for (int i = 0; i < 11; i++) begin
         present(vecs[i].instr, vecs[i].pc);
         rf_rdata1 = vecs[i].rdata1;
         rf_rdata2 = vecs[i].rdata2;
         wb_wen    = vecs[i].wb_wen;
         wb_rd     = vecs[i].wb_rd;
         wb_wdata  = vecs[i].wb_wdata;
         #1;
         chk($sformatf("v%0d_rf_rs1", i), {27'b0, rf_rs1}, {27'b0, vecs[i].e_rs1});
         chk($sformatf("v%0d_rf_rs2", i), {27'b0, rf_rs2}, {27'b0, vecs[i].e_rs2});
         chk($sformatf("v%0d_if_ready", i), {31'b0, if_ready}, 32'h1);
         step();
         chk($sformatf("v%0d_ex_valid", i), {31'b0, ex_valid}, 32'h1);
         chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
         chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].e_imm);
         chk($sformatf("v%0d_rs1_val", i), ex_rs1_val, vecs[i].e_rs1_val);
         chk($sformatf("v%0d_rs2_val", i), ex_rs2_val, vecs[i].e_rs2_val);
         chk($sformatf("v%0d_ex_rs1", i), {27'b0, ex_rs1}, {27'b0, vecs[i].e_rs1});
         chk($sformatf("v%0d_ex_rs2", i), {27'b0, ex_rs2}, {27'b0, vecs[i].e_rs2});
         chk($sformatf("v%0d_ex_rd", i), {27'b0, ex_rd}, {27'b0, vecs[i].e_rd});
         chk($sformatf("v%0d_funct3", i), {29'b0, ex_funct3}, {29'b0, vecs[i].e_f3});
         chk($sformatf("v%0d_alt", i), {31'b0, ex_alt}, {31'b0, vecs[i].e_alt});
         chk($sformatf("v%0d_cls", i), {23'b0, cls_now()}, {23'b0, vecs[i].e_cls});
         chk($sformatf("v%0d_reg_wen", i), {31'b0, ex_reg_wen}, {31'b0, vecs[i].e_wen});
         chk($sformatf("v%0d_illegal", i), {31'b0, ex_illegal}, {31'b0, vecs[i].e_ill});
         idle_inputs();
         step();
         chk($sformatf("v%0d_bubble_valid", i), {31'b0, ex_valid}, 32'h0);
         chk($sformatf("v%0d_bubble_wen", i), {31'b0, ex_reg_wen}, 32'h0);
      end

      // load-use: lw x5,0(x1) held, then add x6,x5,x1 must stall one cycle
      present(32'h0000A283, 32'h200);
      step();
      chk("lu_lw_valid", {31'b0, ex_valid}, 32'h1);
      chk("lu_lw_is_load", {31'b0, ex_is_load}, 32'h1);
      present(32'h00500093, 32'h204);
      #1;
      chk("lu_unused_rs2_ready", {31'b0, if_ready}, 32'h1);
      present(32'h00128333, 32'h204);
      #1;
      chk("lu_stall_ready", {31'b0, if_ready}, 32'h0);
      step();
      chk("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
      chk("lu_bubble_wen", {31'b0, ex_reg_wen}, 32'h0);
      chk("lu_after_ready", {31'b0, if_ready}, 32'h1);
      step();
      chk("lu_add_valid", {31'b0, ex_valid}, 32'h1);
      chk("lu_add_rd", {27'b0, ex_rd}, 32'd6);
      chk("lu_add_is_op", {31'b0, ex_is_op}, 32'h1);
      chk("lu_add_pc", ex_pc, 32'h204);

      // backpressure: lui held for three cycles while execute stalls
      present(32'h123453B7, 32'h300);
      step();
      ex_ready = 1'b0;
      present(32'h00500093, 32'h304);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d_if_ready", k), {31'b0, if_ready}, 32'h0);
         step();
         chk($sformatf("bp%0d_valid", k), {31'b0, ex_valid}, 32'h1);
         chk($sformatf("bp%0d_imm", k), ex_imm, 32'h12345000);
         chk($sformatf("bp%0d_rd", k), {27'b0, ex_rd}, 32'd7);
         chk($sformatf("bp%0d_pc", k), ex_pc, 32'h300);
      end
      ex_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'b0, if_ready}, 32'h1);
      step();
      chk("bp_next_imm", ex_imm, 32'h5);
      chk("bp_next_pc", ex_pc, 32'h304);
      chk("bp_next_opimm", {31'b0, ex_is_opimm}, 32'h1);

      // flush while execute stalls with a valid incoming instruction
      ex_ready = 1'b0;
      present(32'h004101B3, 32'h308);
      flush = 1'b1;
      #1;
      chk("fl_if_ready", {31'b0, if_ready}, 32'h1);
      step();
      chk("fl_valid", {31'b0, ex_valid}, 32'h0);
      chk("fl_reg_wen", {31'b0, ex_reg_wen}, 32'h0);
      flush = 1'b0;
      if_valid = 1'b0;
      ex_ready = 1'b1;
      step();
      chk("fl_dropped", {31'b0, ex_valid}, 32'h0);

      // asynchronous reset between edges
      present(32'h001000EF, 32'h400);
      step();
      chk("ar_pre_valid", {31'b0, ex_valid}, 32'h1);
      idle_inputs();
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", {31'b0, ex_valid}, 32'h0);
      chk("ar_imm", ex_imm, 32'h0);
      chk("ar_pc", ex_pc, 32'h0);
      step();
      rst = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
